// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-outstanding request controller in front of one fpu.
// Accepts a request, holds operands for LATENCY cycles, captures fpu_outp and
// returns it with the caller's tag over a valid/ready response port.
// Optional NaN flag on the response: define FPU_ISSUE_NAN_CHECK_EN.
module fpu_issue_ctrl #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   output logic [1:0]       fpu_opcode,
   input  logic [31:0]      fpu_outp,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_nan,
   output logic [15:0]      ops_done
);

   localparam logic [7:0] LAT8 = 8'(LATENCY);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt;
   logic       accept;
   logic       capture;
   logic       complete;

   assign accept   = req_valid & req_ready;
   assign capture  = (state == BUSY) && (cnt == 8'd1);
   assign complete = rsp_valid & rsp_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)   state_nxt = BUSY;
         BUSY:    if (capture)  state_nxt = DONE;
         DONE:    if (complete) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      req_ready = (state == IDLE) & ~rst;
      rsp_valid = (state == DONE);
   end

   // Latency down-counter, loaded on acceptance
   always_ff @(posedge clk) begin
      if (rst)                cnt <= '0;
      else if (accept)        cnt <= LAT8;
      else if (state == BUSY) cnt <= cnt - 8'd1;
   end

   // Operand hold registers driving the fpu
   always_ff @(posedge clk) begin
      if (rst) begin
         fpu_a      <= '0;
         fpu_b      <= '0;
         fpu_opcode <= '0;
      end else if (accept) begin
         fpu_a      <= req_a;
         fpu_b      <= req_b;
         fpu_opcode <= req_op;
      end
   end

   // Response payload: tag taken at acceptance, data at capture
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_tag  <= '0;
         rsp_data <= '0;
      end else begin
         if (accept)  rsp_tag  <= req_tag;
         if (capture) rsp_data <= fpu_outp;
      end
   end

   // Completed-response counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst)           ops_done <= '0;
      else if (complete) ops_done <= ops_done + 16'd1;
   end

`ifdef FPU_ISSUE_NAN_CHECK_EN
   logic nan_q;

   // NaN flag: all-ones exponent with non-zero mantissa, taken at capture
   always_ff @(posedge clk) begin
      if (rst)          nan_q <= 1'b0;
      else if (capture) nan_q <= (fpu_outp[30:23] == 8'hFF) && (fpu_outp[22:0] != 23'd0);
   end

   assign rsp_nan = nan_q;
`else
   assign rsp_nan = 1'b0;
`endif

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Request-side controller that drives the `fpu` operand interface (`A`, `B`, `opcode`) and collects `outp`. It accepts one operation at a time over a valid/ready request port and holds the operands stable for a fixed result latency. It then captures the result and returns it over a valid/ready response port. It sits between any command source (sequencer, bus slave, bench) and a single `fpu` instance.

## Interface
- `LATENCY`, 4, `fpu` cycles from stable operands to valid `outp`; legal range 1..255
- `TAG_W`, 4, width of the request tag echoed on the response

- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `req_valid` input 1: request present
- `req_ready` output 1: controller can accept a request
- `req_a` input 32: operand A, IEEE-754 single
- `req_b` input 32: operand B, IEEE-754 single
- `req_op` input 2: opcode passed through to `fpu`
- `req_tag` input TAG_W: caller tag
- `fpu_a` output 32: to `fpu.A`
- `fpu_b` output 32: to `fpu.B`
- `fpu_opcode` output 2: to `fpu.opcode`
- `fpu_outp` input 32: from `fpu.outp`
- `rsp_valid` output 1: response present
- `rsp_ready` input 1: consumer accepts response
- `rsp_data` output 32: captured result
- `rsp_tag` output TAG_W: tag of the completed request
- `rsp_nan` output 1: result is a NaN (see Configuration)
- `ops_done` output 16: completed-response counter

## Operation
- States:
  - IDLE: `req_ready`=1.
  - BUSY: operands held, down-counter running.
  - DONE: `rsp_valid`=1.
- IDLE→BUSY on `req_valid & req_ready`:
  - Registers `req_a`/`req_b`/`req_op` into `fpu_a`/`fpu_b`/`fpu_opcode`.
  - Registers `req_tag` into `rsp_tag`.
  - Loads the counter with LATENCY.
- BUSY: the counter decrements each cycle. When the counter equals 1, the next edge captures `fpu_outp` into `rsp_data` and enters DONE.
- DONE→IDLE on `rsp_valid & rsp_ready`. `ops_done` increments on that edge and wraps 0xFFFF→0x0000.
- `req_ready` = (state==IDLE) & ~`rst`. No request is accepted in BUSY or DONE, including the cycle a response handshakes.
- `fpu_a`, `fpu_b`, `fpu_opcode` change only on request acceptance. They hold their last values in all other states, including after completion.
- `rsp_data`, `rsp_tag`, `rsp_nan` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- `req_*` values outside an accepting cycle are ignored.
- The counter is 8 bits wide.

## Timing
- Reset, applied on the edge where `rst`=1:
  - state=IDLE, counter=0, `ops_done`=0.
  - `fpu_a`=`fpu_b`=0, `fpu_opcode`=0.
  - `rsp_data`=0, `rsp_tag`=0, `rsp_nan`=0, `rsp_valid`=0.
  - `req_ready`=0 while `rst` is high and 1 in the first cycle after it drops.
- Reset asserted in BUSY or DONE aborts the operation. No response is produced and `ops_done` is unchanged from its reset value of 0.
- Request accepted at edge T:
  - Operands on `fpu_*` from T through capture.
  - `fpu_outp` sampled at edge T+LATENCY.
  - `rsp_valid`=1 from the cycle after edge T+LATENCY.
- Minimum initiation interval with `rsp_ready` tied high: LATENCY+2 cycles.
- LATENCY=1: BUSY lasts exactly one cycle.

## Configuration
- `FPU_ISSUE_NAN_CHECK_EN` defined: `rsp_nan` is registered at capture as (`fpu_outp[30:23]`==8'hFF) & (`fpu_outp[22:0]`!=0).
- `FPU_ISSUE_NAN_CHECK_EN` undefined: `rsp_nan` is tied to 0 and no NaN logic is synthesised.

## Test plan
The bench uses a behavioural `fpu` model with LATENCY=4. The model returns a correct add result 4 cycles after the operands settle.

- Reset: hold `rst` 3 cycles with `req_valid`=1 → `req_ready`=0, `rsp_valid`=0, `fpu_a`=0, `ops_done`=0. `req_ready`=1 in the first cycle after release.
- Basic add: `req_a`=0x40000000, `req_b`=0x40400000, `req_op`=0, `req_tag`=5, `rsp_ready`=1 → `rsp_valid` exactly 5 cycles after acceptance with `rsp_data`=0x40A00000, `rsp_tag`=5; `ops_done`=1.
- Backpressure: same request with `rsp_ready`=0 for 10 cycles → `rsp_valid` held and data/tag stable. `req_ready`=0 throughout and a second `req_valid` is ignored. It is accepted only after the `rsp_ready` pulse.
- Back-to-back: 3 requests with tags 1,2,3 and `req_valid` held high → responses in order 1,2,3, each 6 cycles apart.
- Abort: assert `rst` 2 cycles into BUSY → no `rsp_valid`, state IDLE, all outputs at reset values.
- NaN:
  - With `FPU_ISSUE_NAN_CHECK_EN` defined, a model result of 0x7FC00000 → `rsp_nan`=1, and 0x7F800000 → `rsp_nan`=0.
  - With the macro undefined, `rsp_nan`=0 for both.
